// File: rtl/serial_sub_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester uses the master modport; the sequencer uses the slave modport.
interface serial_sub_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff_o;
    logic         bout_o;

    modport master (
        output start, a_i, b_i,
        input  ready, busy, done, diff_o, bout_o
    );

    modport slave (
        input  start, a_i, b_i,
        output ready, busy, done, diff_o, bout_o
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b sequencer, LSB first, sharing one full_sub_st cell.
// Define SERIAL_SUB_SAT_EN for an unsigned saturating result (clamped to 0 on borrow).
module full_sub_st (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub_ctrl #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   res_reg;
    logic           borrow_reg;
    logic [CW-1:0]  count_reg;
    logic           ready_reg;
    logic           busy_reg;
    logic           done_reg;
    logic [W-1:0]   diff_reg;
    logic           bout_reg;

    logic           bit_diff;
    logic           bit_bout;
    logic [W-1:0]   res_next;
    logic [W-1:0]   final_diff;

    full_sub_st u_full_sub (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (borrow_reg),
        .diff (bit_diff),
        .bout (bit_bout)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    assign res_next = (res_reg >> 1) | (W'(bit_diff) << (W - 1));

`ifdef SERIAL_SUB_SAT_EN
    assign final_diff = bit_bout ? '0 : res_next;
`else
    assign final_diff = res_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg      <= bus.a_i;
                        b_reg      <= bus.b_i;
                        borrow_reg <= 1'b0;
                        count_reg  <= '0;
                        ready_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg      <= a_reg >> 1;
                    b_reg      <= b_reg >> 1;
                    res_reg    <= res_next;
                    borrow_reg <= bit_bout;
                    count_reg  <= count_reg + 1'b1;
                    // Last bit: publish the result in the same edge it completes.
                    if (count_reg == LAST) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        diff_reg  <= final_diff;
                        bout_reg  <= bit_bout;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ready  = ready_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.diff_o = diff_reg;
    assign bus.bout_o = bout_reg;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: W=8 and W=1 instances against an arithmetic reference model.
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.W(8)) bus8 ();
    serial_sub_ctrl_if #(.W(1)) bus1 ();

    serial_sub_ctrl #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_sub_ctrl #(.W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks   = 0;
    int failures = 0;
    logic [7:0] last_d;
    logic       last_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {borrow, difference} from plain unsigned arithmetic.
    function automatic logic [8:0] model8(input int a, input int b);
        int d;
        logic bo;
        bo = (a < b);
        d  = (a + 256 - b) % 256;
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = 0;
`endif
        return {bo, d[7:0]};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit glitch);
        logic [8:0] exp;
        int done_at, done_cnt, busy_cnt;
        logic [7:0] got_d;
        logic got_b;
        exp = model8(int'(a), int'(b));
        done_at = -1; done_cnt = 0; busy_cnt = 0; got_d = 8'h00; got_b = 1'b0;
        @(negedge clk);
        chk("ready_before_start", bus8.ready, 1);
        bus8.start = 1'b1; bus8.a_i = a; bus8.b_i = b;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a_i = ~a;
        for (int k = 0; k < W + 4; k++) begin
            if (bus8.done) begin
                done_cnt++; done_at = k; got_d = bus8.diff_o; got_b = bus8.bout_o;
            end
            if (bus8.busy) busy_cnt++;
            if (k == 0) chk("hold_diff_during_shift", bus8.diff_o, last_d);
            if (k == W - 1) chk("hold_bout_during_shift", bus8.bout_o, last_b);
            if (glitch && k == 2) begin
                bus8.start = 1'b1; bus8.a_i = 8'($urandom); bus8.b_i = 8'($urandom);
            end
            if (glitch && k == 3) bus8.start = 1'b0;
            @(negedge clk);
        end
        chk("done_latency", done_at, W);
        chk("done_pulse_count", done_cnt, 1);
        chk("busy_cycles", busy_cnt, W);
        chk("diff", got_d, exp[7:0]);
        chk("bout", got_b, exp[8]);
        chk("diff_held_after_done", bus8.diff_o, exp[7:0]);
        $display("op a=%02h b=%02h glitch=%0d -> diff=%02h bout=%0d done_at=%0d", a, b, glitch, got_d, got_b, done_at);
        last_d = exp[7:0];
        last_b = exp[8];
    endtask

    initial begin
        logic [8:0] e1, e2;
        int dn, nd;
        logic a1, b1, e1d, e1b;

        rst = 1'b1;
        bus8.start = 1'b0; bus8.a_i = '0; bus8.b_i = '0;
        bus1.start = 1'b0; bus1.a_i = '0; bus1.b_i = '0;
        last_d = 8'h00; last_b = 1'b0;
        #12;
        chk("rst_ready", bus8.ready, 1);
        chk("rst_busy", bus8.busy, 0);
        chk("rst_done", bus8.done, 0);
        chk("rst_diff", bus8.diff_o, 0);
        chk("rst_bout", bus8.bout_o, 0);
        chk("rst_ready_w1", bus1.ready, 1);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h23, 1'b0);
        run_op(8'h10, 8'h20, 1'b0);

        // Back-to-back with start held high; operands switched right after acceptance.
        e1 = model8(255, 255);
        e2 = model8(0, 1);
        dn = 0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a_i = 8'hFF; bus8.b_i = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus8.a_i = 8'h00; bus8.b_i = 8'h01;
        for (int k = 0; k < 2 * W + 4; k++) begin
            if (bus8.done) dn++;
            if (k == W) begin
                chk("b2b_first_done", bus8.done, 1);
                chk("b2b_first_diff", bus8.diff_o, e1[7:0]);
                chk("b2b_first_bout", bus8.bout_o, e1[8]);
            end
            if (k == W + 1) chk("b2b_ready_gap", bus8.ready, 1);
            if (k == W + 2) begin
                chk("b2b_second_busy", bus8.busy, 1);
                bus8.start = 1'b0;
            end
            if (k > W && k < 2 * W + 2 && bus8.diff_o !== e1[7:0])
                chk("b2b_diff_hold", bus8.diff_o, e1[7:0]);
            if (k == 2 * W + 2) begin
                chk("b2b_second_done", bus8.done, 1);
                chk("b2b_second_diff", bus8.diff_o, e2[7:0]);
                chk("b2b_second_bout", bus8.bout_o, e2[8]);
            end
            @(negedge clk);
        end
        chk("b2b_done_count", dn, 2);
        $display("b2b first=%03h second=%03h dones=%0d", e1, e2, dn);
        last_d = e2[7:0]; last_b = e2[8];

        run_op(8'h9C, 8'h21, 1'b1);

        // Asynchronous reset during the fourth SHIFT cycle.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a_i = 8'hC3; bus8.b_i = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", bus8.ready, 1);
        chk("arst_busy", bus8.busy, 0);
        chk("arst_done", bus8.done, 0);
        chk("arst_diff", bus8.diff_o, 0);
        chk("arst_bout", bus8.bout_o, 0);
        $display("async reset mid-shift diff=%02h bout=%0d", bus8.diff_o, bus8.bout_o);
        last_d = 8'h00; last_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (bus8.done) nd++;
            @(negedge clk);
        end
        chk("arst_no_done", nd, 0);
        run_op(8'hC3, 8'h3C, 1'b0);

        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 16; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        // W=1 instance.
        for (int i = 0; i < 2; i++) begin
            a1 = (i == 1);
            b1 = (i == 0);
            e1d = 1'((int'(a1) + 2 - int'(b1)) % 2);
            e1b = (a1 < b1);
`ifdef SERIAL_SUB_SAT_EN
            if (e1b) e1d = 1'b0;
`endif
            @(negedge clk);
            chk("w1_ready", bus1.ready, 1);
            bus1.start = 1'b1; bus1.a_i = a1; bus1.b_i = b1;
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            chk("w1_busy", bus1.busy, 1);
            chk("w1_done_early", bus1.done, 0);
            @(negedge clk);
            chk("w1_done", bus1.done, 1);
            chk("w1_diff", bus1.diff_o, e1d);
            chk("w1_bout", bus1.bout_o, e1b);
            $display("w1 a=%0d b=%0d -> diff=%0d bout=%0d", a1, b1, bus1.diff_o, bus1.bout_o);
            @(negedge clk);
            chk("w1_done_clear", bus1.done, 0);
            chk("w1_ready_after", bus1.ready, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction sequencer. It computes an unsigned W-bit difference a - b one bit per cycle, LSB first, through a single instance of the team's one-bit full subtractor cell (full_sub_st) and a registered borrow. It provides a start/done handshake so any datapath needing an area-cheap subtract can share one 1-bit subtractor.

Parameters:
W, 8, operand/result width in bits; legal range W >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when ready=1
a_i  input  W  minuend, captured on accepted start
b_i  input  W  subtrahend, captured on accepted start
ready  output  1  high in IDLE; start is accepted this cycle
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; diff_o/bout_o are valid
diff_o  output  W  result a - b mod 2^W; held until next accepted start
bout_o  output  1  final borrow (1 when a < b); held with diff_o

Behaviour:
- Reset (async, any state): state=IDLE, shift regs=0, borrow reg=0, count=0, diff_o=0, bout_o=0, ready=1, busy=0, done=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On a clock edge with start=1: load A<=a_i, B<=b_i, borrow<=0, count<=0; go to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT:
  - busy=1, ready=0.
  - Each edge: full_sub_st(a=A[0], b=B[0], bin=borrow) produces diff and bout.
  - A and B shift right by 1. Diff shifts into the result register MSB; the result register shifts right. borrow<=bout; count<=count+1.
  - On the edge where count==W-1 (the Wth bit): go to DONE; result register holds the full difference and borrow holds the final borrow.
- DONE:
  - done=1 for exactly one cycle; busy=0, ready=0.
  - diff_o/bout_o update to the final values on entry to DONE.
  - Next edge: go to IDLE.
- Latency: start accepted at edge 0; done high during the cycle following edge W. Next start can be accepted at edge W+2, so throughput is one operation per W+2 cycles.
- diff_o/bout_o:
  - Registered, and change only on entry to DONE.
  - Stable in IDLE and SHIFT, including during a new operation, until the next DONE.
- start while busy or in DONE is ignored; there is no queuing.
- a_i/b_i changes after the accepted start have no effect.
- Counter width is clog2(W+1). The W=1 case completes in one SHIFT cycle.
- Reset mid-SHIFT aborts the operation: no done pulse, and diff_o/bout_o return to 0.
- Unsigned arithmetic only; bout_o=1 iff a_i < b_i.

Optional Feature:
- Macro: SERIAL_SUB_SAT_EN.
- Defined: unsigned saturating subtract. On entry to DONE, if the final borrow is 1, diff_o is forced to 0 and bout_o=1; otherwise the behaviour is unchanged. Latency is unchanged.
- Undefined: wrap-around result as specified above (modulo 2^W).

Test Plan:
- W=8, a=0x5A, b=0x23, start one cycle -> done pulses exactly 9 cycles after the start edge; diff_o=0x37, bout_o=0; busy high for 8 cycles.
- W=8, a=0x10, b=0x20 -> diff_o=0xF0, bout_o=1. With SERIAL_SUB_SAT_EN -> diff_o=0x00, bout_o=1.
- W=8, a=0xFF, b=0xFF, then a=0x00, b=0x01 back-to-back (start held high) -> first result 0x00/0; second accepted at edge 10 gives 0xFF/1. diff_o stays 0x00 until the second done.
- Start pulse mid-SHIFT with different a/b, and a_i changed after acceptance -> ignored; result matches the originally captured operands; exactly one done pulse.
- Assert rst asynchronously (between edges) during cycle 4 of SHIFT -> outputs immediately ready=1, busy=0, done=0, diff_o=0, bout_o=0; no done follows. A new start then gives a correct result.
- W=1 build: a=0, b=1 -> done 2 cycles after the start edge; diff_o=1, bout_o=1. a=1, b=0 -> diff_o=1, bout_o=0.
